memwb_skid_reg: RTL
===================

MEMWB_SKID_REG -- requirements
Module: memwb_skid_reg

Interface
REQ-001 Parameter XLEN, default 32, shall set the width of the write-back data path.
REQ-002 Parameter RADDR_W, default 5, shall set the width of the destination register index.
REQ-003 Parameter ZERO_SUPPRESS, default 1, shall force the write enable low when the destination index is 0.
REQ-004 Port clk, input, 1 bit, shall be the clock; rising edge active.
REQ-005 Port rst_n, input, 1 bit, shall be the reset: asynchronous, active-low.
REQ-006 Port flush, input, 1 bit, shall be the synchronous pipeline kill.
REQ-007 Port in_valid, input, 1 bit, shall mark the MEM-stage beat as valid.
REQ-008 Port in_ready, output, 1 bit, shall indicate the block accepts a beat.
REQ-009 Port in_wb_en, input, 1 bit, shall be the write-back request.
REQ-010 Port in_rd, input, RADDR_W bits, shall be the destination register index.
REQ-011 Port in_result, input, XLEN bits, shall be the write-back data.
REQ-012 Port in_s_flag, input, 1 bit, shall be the stage-valid/commit flag.
REQ-013 Port out_ready, input, 1 bit, shall mean the WB stage or regfile accepts the head beat.
REQ-014 Port out_valid, output, 1 bit, shall mean a head entry is present.
REQ-015 Port regbag_w_en, output, 1 bit, shall be the regfile write strobe.
REQ-016 Port regbag_w_addr, output, RADDR_W bits, shall be the head entry's destination index.
REQ-017 Port regbag_w_data, output, XLEN bits, shall be the head entry's data.
REQ-018 Port s_flag_o, output, 1 bit, shall be the head s_flag qualified by out_valid.
REQ-019 Port occ, output, 2 bits, shall report the entry count (0..2).

Function
REQ-020 Storage shall be a 2-entry skid buffer (HEAD, SKID) with states EMPTY, ONE and FULL, and occ shall equal 0, 1 and 2 respectively.
REQ-021 in_ready shall be a registered signal equal to (state != FULL); no combinational path from out_ready to in_ready shall exist.
REQ-022 An accept shall occur when in_valid and in_ready are both high; a pop shall occur when out_valid and out_ready are both high.
REQ-023 Transitions shall be:
- EMPTY with accept -> ONE.
- ONE with accept and no pop -> FULL.
- ONE with pop and no accept -> EMPTY.
- ONE with accept and pop -> ONE, HEAD replaced by the new beat.
- FULL with pop -> ONE, SKID moves to HEAD.
- All other cases hold state.
REQ-024 Latency from accept into EMPTY to out_valid shall be exactly 1 cycle; beats shall leave in acceptance order with no loss or duplication.
REQ-025 regbag_w_en shall equal out_valid & out_ready & head.wb_en & head.s_flag & ((head.rd != 0) | !ZERO_SUPPRESS).
REQ-026 A beat with s_flag = 0 shall still occupy an entry and pop normally, but shall never assert regbag_w_en.
REQ-027 While out_valid = 0, regbag_w_en and s_flag_o shall be 0; regbag_w_addr and regbag_w_data shall hold their last values.
REQ-028 flush shall force state EMPTY at the next edge, overriding any simultaneous accept or pop; regbag_w_en shall be masked to 0 in the flush cycle.
REQ-029 A beat presented while state = FULL shall not be accepted, and the upstream stage shall hold it.

Reset
REQ-030 While rst_n = 0, the block shall force state EMPTY, occ 0, out_valid 0, regbag_w_en 0, s_flag_o 0, regbag_w_addr 0, regbag_w_data 0 and both entries' stored fields 0.
REQ-031 in_ready shall be 0 during reset and 1 on the first edge after rst_n deasserts.
REQ-032 Reset asserted mid-operation shall discard all entries with no regfile write.

Structure
REQ-033 A shared package shall hold the wb_beat_t struct {wb_en, rd, result, s_flag} and the state encoding constants EMPTY, ONE and FULL.
REQ-034 No sub-module shall be required; the two entries shall be instances of wb_beat_t inside this module.

Verification
REQ-035 With rst_n released and out_ready = 1, accept {wb_en 1, rd 5, result 0xDEADBEEF, s_flag 1}; next cycle regbag_w_en = 1, addr 5, data 0xDEADBEEF, and occ returns to 0 after the pop.
REQ-036 With out_ready = 0, accept beats A (rd 1) and B (rd 2); occ = 2 and in_ready = 0; a third beat C is held; raise out_ready: writes rd 1, then rd 2, then rd 3 on consecutive cycles.
REQ-037 Accept rd 0 with wb_en 1: with ZERO_SUPPRESS = 1 regbag_w_en = 0; with ZERO_SUPPRESS = 0 regbag_w_en = 1.
REQ-038 Accept beat with s_flag 0 and wb_en 1: regbag_w_en stays 0, and the beat pops with occ 1 -> 0.
REQ-039 At FULL, assert flush together with in_valid and out_ready: no write, occ = 0 and in_ready = 1 next cycle, and the flushed input is not accepted.
REQ-040 Drop rst_n while FULL: all outputs go to 0 immediately; after release, no spurious regbag_w_en occurs.

Source files
------------

// File: rtl/memwb_skid_reg_pkg.sv
// Shared types for the MEM/WB skid register.
//   wb_beat_t     : one write-back beat {wb_en, rd, result, s_flag}
//   skid_state_e  : occupancy state; the encoding equals the entry count
//   beat_commits  : true when a beat at the head may write the regfile
// The struct widths are the block's default XLEN / RADDR_W. Instances must
// keep XLEN and RADDR_W equal to WB_XLEN and WB_RADDR_W.
package memwb_skid_reg_pkg;

    localparam int unsigned WB_XLEN    = 32;
    localparam int unsigned WB_RADDR_W = 5;

    // Encoding doubles as the occupancy count reported on occ.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic                  wb_en;
        logic [WB_RADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]    result;
        logic                  s_flag;
    } wb_beat_t;

    // A beat commits only if it requests write-back, is a committed
    // (stage-valid) beat, and does not target x0 while suppression is on.
    function automatic logic beat_commits(input wb_beat_t beat, input logic zero_suppress);
        return beat.wb_en & beat.s_flag &
               ((beat.rd != {WB_RADDR_W{1'b0}}) | ~zero_suppress);
    endfunction

endpackage

// File: rtl/memwb_skid_reg.sv
// MEM/WB pipeline register built as a 2-entry skid buffer (HEAD, SKID).
// in_ready is registered so the upstream handshake never depends
// combinationally on out_ready; the SKID entry absorbs the one beat that can
// arrive in the cycle the downstream stalls.
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   flush                    synchronous kill: empties the buffer next edge
//   in_valid / in_ready      upstream handshake
//   in_wb_en, in_rd,
//   in_result, in_s_flag     incoming beat fields
//   out_ready / out_valid    downstream handshake on the HEAD entry
//   regbag_w_en/_addr/_data  regfile write port driven from HEAD
//   s_flag_o                 HEAD s_flag qualified by out_valid
//   occ                      number of stored entries (0..2)
module memwb_skid_reg
    import memwb_skid_reg_pkg::*;
#(
    parameter int unsigned XLEN          = WB_XLEN,
    parameter int unsigned RADDR_W       = WB_RADDR_W,
    parameter bit          ZERO_SUPPRESS = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_wb_en,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]    in_result,
    input  logic               in_s_flag,
    input  logic               out_ready,
    output logic               out_valid,
    output logic               regbag_w_en,
    output logic [RADDR_W-1:0] regbag_w_addr,
    output logic [XLEN-1:0]    regbag_w_data,
    output logic               s_flag_o,
    output logic [1:0]         occ
);

    skid_state_e state_r;
    skid_state_e state_nx_s;
    logic        in_ready_r;
    wb_beat_t    head_r;
    wb_beat_t    skid_r;
    wb_beat_t    in_beat_s;
    logic        accept_s;
    logic        pop_s;
    logic        out_valid_s;
    logic        w_en_s;
    logic        s_flag_s;
    logic [1:0]  occ_s;

    // Pack the incoming fields into one beat.
    always_comb begin
        in_beat_s        = '0;
        in_beat_s.wb_en  = in_wb_en;
        in_beat_s.rd     = in_rd;
        in_beat_s.result = in_result;
        in_beat_s.s_flag = in_s_flag;
    end

    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_s & out_ready;

    // State register; in_ready is registered from the next state so it is
    // exactly (state != FULL) without any path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= EMPTY;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            in_ready_r <= (state_nx_s != FULL);
        end
    end

    // Next-state logic; flush wins over any accept or pop.
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) state_nx_s = ONE;
                    else          state_nx_s = EMPTY;
                end
                ONE: begin
                    if (accept_s && !pop_s)      state_nx_s = FULL;
                    else if (pop_s && !accept_s) state_nx_s = EMPTY;
                    else                         state_nx_s = ONE;
                end
                FULL: begin
                    if (pop_s) state_nx_s = ONE;
                    else       state_nx_s = FULL;
                end
                default: state_nx_s = EMPTY;
            endcase
        end
    end

    // Entry storage. Entries are left untouched on pop-to-empty and on
    // flush so the write address/data hold their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= '0;
            skid_r <= '0;
        end else if (!flush) begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) head_r <= in_beat_s;
                end
                ONE: begin
                    if (accept_s && pop_s) head_r <= in_beat_s;
                    else if (accept_s)     skid_r <= in_beat_s;
                end
                FULL: begin
                    if (pop_s) head_r <= skid_r;
                end
                default: ;
            endcase
        end
    end

    // Output decode from the state register and HEAD entry.
    always_comb begin
        out_valid_s = 1'b0;
        occ_s       = 2'd0;
        w_en_s      = 1'b0;
        s_flag_s    = 1'b0;
        case (state_r)
            EMPTY: begin
                out_valid_s = 1'b0;
                occ_s       = 2'd0;
            end
            ONE: begin
                out_valid_s = 1'b1;
                occ_s       = 2'd1;
            end
            FULL: begin
                out_valid_s = 1'b1;
                occ_s       = 2'd2;
            end
            default: begin
                out_valid_s = 1'b0;
                occ_s       = 2'd0;
            end
        endcase
        // A flushed beat must never reach the regfile.
        if (out_valid_s && !flush) begin
            w_en_s = out_ready & beat_commits(head_r, ZERO_SUPPRESS);
        end else begin
            w_en_s = 1'b0;
        end
        s_flag_s = out_valid_s & head_r.s_flag;
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_s;
    assign regbag_w_en   = w_en_s;
    assign regbag_w_addr = head_r.rd;
    assign regbag_w_data = head_r.result;
    assign s_flag_o      = s_flag_s;
    assign occ           = occ_s;

endmodule
